fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder buffer placed directly after the streaming FFT core.
- The FFT core emits each frame in bit-reversed bin order; this block writes samples into a ping-pong RAM at bit-reversed addresses and reads them back in natural bin order (0..FFT_N-1).
- The output is a continuous one-sample-per-cycle stream with frame markers, ready for the readout and monitoring logic downstream.

Parameters:
- FFT_N, 1024, points per frame; power of two, at least 4; address width AW = $clog2(FFT_N).
- DATA_W, 16, width of the signed real and imaginary sample parts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid; a sample is captured on any edge where in_valid=1.
- in_first  in  1  qualified by in_valid; marks bit-reversed index 0 of a frame.
- in_re  in  DATA_W  signed real part, bit-reversed order.
- in_im  in  DATA_W  signed imaginary part, bit-reversed order.
- out_valid  out  1  output sample valid.
- out_first  out  1  asserted with bin 0.
- out_last  out  1  asserted with bin FFT_N-1.
- out_bin  out  AW  natural-order bin index of the current output.
- out_re  out  DATA_W  signed real part, natural order.
- out_im  out  DATA_W  signed imaginary part, natural order.

Behaviour:
- Reset (asynchronous): clear all outputs, wr_cnt, wr_bank, the read state and the pending flag to 0.
- Storage: two banks of FFT_N x (2*DATA_W). Write is synchronous; read is registered with 1-cycle read latency. No arithmetic; data passes through bit-exact.
- Write side, on each edge with in_valid=1:
  - The write address is bitrev_AW(wr_cnt), or bitrev(0)=0 if in_first=1, into bank wr_bank.
  - in_first=1 forces this sample to index 0 and sets wr_cnt to 1, so partial frames are discarded.
  - wr_cnt is otherwise incremented.
  - When the written index equals FFT_N-1: wr_cnt wraps to 0, wr_bank toggles, and the filled bank is handed to the reader.
  - Gaps in in_valid stall writing only.
  - Before the first in_first after reset, samples are written starting at wr_cnt=0, i.e. the stream is implicitly aligned.
- Read FSM, states IDLE and READ:
  - IDLE -> READ on the edge after a bank handoff. Latch rd_bank and set rd_cnt=0.
  - In READ, issue the read of address rd_cnt every cycle. rd_cnt increments, so there are no bubbles.
  - When rd_cnt=FFT_N-1 is issued: go to READ again (rd_bank toggled, rd_cnt=0) if pending=1, otherwise go to IDLE.
  - A handoff that occurs while in READ sets pending. It cannot occur at matched rates but must be handled. The reader is never stalled.
  - out_valid, out_first, out_last and out_bin are registered alongside the RAM data, so they are aligned with out_re/out_im.
- Timing:
  - The edge that writes index FFT_N-1 is edge E.
  - Bin 0 is presented after edge E+2.
  - Bin k is presented after edge E+2+k.
  - Back-to-back full-rate input frames yield gap-free output.
- Simultaneous events:
  - A write into bank X and a read from bank Y (Y != X) in the same cycle is always legal.
  - The writer is never stalled. If the writer wraps onto a bank still being read, which only happens with a protocol violation, data is overwritten without detection.
- Output values while out_valid=0:
  - out_re, out_im and out_bin hold their last values.
  - out_first and out_last are 0.
- Reset mid-operation: outputs are cleared immediately. The next output appears only after a complete new frame has been written.

Optional Feature:
- REORDER_FRAME_ERR_EN defined:
  - Adds output port frame_err (1 bit), a sticky flag that is cleared only by rst.
  - It is set on the edge where in_valid=1, in_first=1 and wr_cnt!=0, i.e. a frame resync that discarded a partial frame.
  - It is also set on a bank handoff while pending=1 is already set, i.e. overrun.
- REORDER_FRAME_ERR_EN not defined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset check:
  - Stimulus: assert rst mid-cycle with no clock edge.
  - Required response: all outputs 0 immediately; no out_valid until 1024 valid samples are written.
- Single frame:
  - Stimulus: FFT_N=1024; feed index k (k=0..1023) with in_re=bitrev10(k), in_im=-bitrev10(k), in_first at k=0.
  - Required response: out_re=0,1,...,1023 and out_im=0,-1,...,-1023 consecutively; out_first at bin 0; out_last at bin 1023; bin 0 appears at E+2.
- Back-to-back:
  - Stimulus: 3 consecutive full-rate frames with offsets 0, 2000 and 4000.
  - Required response: 3072 consecutive out_valid cycles with no gap, each frame in natural order with the correct offset.
- Bubbles:
  - Stimulus: in_valid pattern 1,0,0,1 repeated for one frame.
  - Required response: identical natural-order output; bin 0 appears 2 edges after the 1024th valid sample.
- Resync:
  - Stimulus: in_first reasserted at write index 300, then a full frame.
  - Required response: the 300 partial samples never appear; exactly one output frame is emitted; frame_err=1 when REORDER_FRAME_ERR_EN is defined.
- Reset mid-read:
  - Stimulus: assert rst at output bin 500.
  - Required response: out_valid=0 at once; remaining bins are never emitted; the next full frame is output correctly.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle between the FFT core, the bit-reverse reorder buffer and readout.
// master drives in_*, slave (the reorder block) drives out_* and optional frame_err.
interface fft_bitrev_reorder_if #(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = 16
);
  localparam int AW = $clog2(FFT_N);

  logic                     in_valid;
  logic                     in_first;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;

  logic                     out_valid;
  logic                     out_first;
  logic                     out_last;
  logic [AW-1:0]            out_bin;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;

`ifdef REORDER_FRAME_ERR_EN
  logic                     frame_err;

  modport master (
    output in_valid, in_first, in_re, in_im,
    input  out_valid, out_first, out_last,
    input  out_bin, out_re, out_im,
    input  frame_err
  );

  modport slave (
    input  in_valid, in_first, in_re, in_im,
    output out_valid, out_first, out_last,
    output out_bin, out_re, out_im,
    output frame_err
  );
`else
  modport master (
    output in_valid, in_first, in_re, in_im,
    input  out_valid, out_first, out_last,
    input  out_bin, out_re, out_im
  );

  modport slave (
    input  in_valid, in_first, in_re, in_im,
    output out_valid, out_first, out_last,
    output out_bin, out_re, out_im
  );
`endif
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes FFT frames at bit-reversed addresses and
// streams them out in natural bin order with first/last markers.
// Ports: clk, rst (async, active-high), io (slave: in_* stream in, out_* out).
// Optional macro REORDER_FRAME_ERR_EN adds sticky io.frame_err (resync/overrun).
module fft_bitrev_reorder #(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  fft_bitrev_reorder_if.slave  io
);
  localparam int AW = $clog2(FFT_N);
  localparam int MW = 2 * DATA_W;
  localparam logic [AW-1:0] LAST = AW'(FFT_N - 1);

  typedef enum logic {IDLE, READ} state_e;

  function automatic logic [AW-1:0] bitrev(
    input logic [AW-1:0] a
  );
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  logic [MW-1:0] mem [2*FFT_N];

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx, wr_addr;
  logic          wr_last, handoff;

  state_e        state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          pending_q, pending_d;
  logic          consume;
  logic [MW-1:0] rd_word;

  logic                     out_valid_q, out_valid_d;
  logic                     out_first_q, out_first_d;
  logic                     out_last_q, out_last_d;
  logic [AW-1:0]            out_bin_q, out_bin_d;
  logic signed [DATA_W-1:0] out_re_q, out_re_d;
  logic signed [DATA_W-1:0] out_im_q, out_im_d;

  // in_first snaps the frame back to index 0, discarding any partial frame.
  always_comb begin
    wr_idx    = io.in_first ? '0 : wr_cnt_q;
    wr_addr   = bitrev(wr_idx);
    wr_last   = (wr_idx == LAST);
    handoff   = io.in_valid && wr_last;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (io.in_valid) begin
      wr_cnt_d = wr_last ? '0 : wr_idx + 1'b1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (io.in_valid)
      mem[{wr_bank_q, wr_addr}] <= {io.in_re, io.in_im};
  end

  // pending records a filled bank not yet picked up by the reader.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    consume     = 1'b0;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_bin_d   = out_bin_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    rd_word     = mem[{rd_bank_q, rd_cnt_q}];
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = READ;
          rd_bank_d = ~wr_bank_q;
          rd_cnt_d  = '0;
          consume   = 1'b1;
        end
      end
      READ: begin
        out_valid_d = 1'b1;
        out_first_d = (rd_cnt_q == '0);
        out_last_d  = (rd_cnt_q == LAST);
        out_bin_d   = rd_cnt_q;
        {out_re_d, out_im_d} = rd_word;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST) begin
          if (pending_q) begin
            rd_bank_d = ~rd_bank_q;
            consume   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
    pending_d = handoff | (pending_q & ~consume);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bin_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_bin_q   <= out_bin_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_first = out_first_q;
  assign io.out_last  = out_last_q;
  assign io.out_bin   = out_bin_q;
  assign io.out_re    = out_re_q;
  assign io.out_im    = out_im_q;

`ifdef REORDER_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // Resync over a partial frame, or a second bank handed off before the
  // first one was picked up.
  always_comb begin
    frame_err_d = frame_err_q;
    if (io.in_valid && io.in_first && wr_cnt_q != '0)
      frame_err_d = 1'b1;
    if (handoff && pending_q && !consume)
      frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end

  assign io.frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed scoreboard bench for fft_bitrev_reorder (FFT_N=1024, DATA_W=16).
// Expected natural-order frames are queued as stimulus completes a frame.
module tb_fft_bitrev_reorder;
  localparam int N  = 1024;
  localparam int DW = 16;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [9:0]  bin;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t exp_q[$];
  int   t_q[$];
  int   frames_out = 0;
  int   run = 0;
  int   last_run = 0;

  fft_bitrev_reorder_if #(.FFT_N(N), .DATA_W(DW)) io ();

  fft_bitrev_reorder #(.FFT_N(N), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] brev(input logic [9:0] x);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = x[9-i];
    return r;
  endfunction

  // Drives indices k0..k1; bub selects the 1,0,0,1 valid pattern.
  task automatic send_range(input int off, input int k0,
                            input int k1, input bit bub);
    int   k;
    int   ph;
    int   v;
    logic [9:0] kk;
    exp_t e;
    k  = k0;
    ph = 0;
    while (k <= k1) begin
      @(negedge clk);
      if (bub && (ph % 4 == 1 || ph % 4 == 2)) begin
        io.in_valid = 1'b0;
        io.in_first = 1'b0;
      end else begin
        kk = k[9:0];
        v  = int'(brev(kk)) + off;
        io.in_valid = 1'b1;
        io.in_first = (k == 0);
        io.in_re    = 16'(v);
        io.in_im    = 16'(-v);
        if (k == N - 1) begin
          t_q.push_back(cyc + 3);
          for (int n = 0; n < N; n++) begin
            e.first = (n == 0);
            e.last  = (n == N - 1);
            e.bin   = n[9:0];
            e.re    = 16'(n + off);
            e.im    = 16'(-(n + off));
            exp_q.push_back(e);
          end
        end
        k++;
      end
      ph++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      io.in_valid = 1'b0;
      io.in_first = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(4);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run = 0;
    end else begin
      if (exp_q.size() == 0)
        check("spurious_valid", 64'(io.out_valid), 64'd0);
      if (io.out_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sample",
              64'({io.out_first, io.out_last, io.out_bin,
                   io.out_re, io.out_im}),
              64'(e));
        if (io.out_first && t_q.size() != 0)
          check("bin0_time", 64'(cyc), 64'(t_q.pop_front()));
      end
      if (!io.out_valid)
        check("idle_marks",
              64'({io.out_first, io.out_last}), 64'd0);
      if (io.out_valid && io.out_last) frames_out++;
      if (io.out_valid) begin
        run++;
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr0;
    io.in_valid = 1'b0;
    io.in_first = 1'b0;
    io.in_re    = '0;
    io.in_im    = '0;

    // Asynchronous reset with no clock edge.
    #3 rst = 1'b1;
    #1;
    check("rst_outs",
          64'({io.out_valid, io.out_first, io.out_last,
               io.out_bin, io.out_re, io.out_im}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1023 samples must not release a frame.
    send_range(0, 0, N - 2, 1'b0);
    idle(30);
    check("no_early_valid", 64'(io.out_valid), 64'd0);
    send_range(0, N - 1, N - 1, 1'b0);
    idle(1);
    drain();

    // Single contiguous frame.
    send_range(0, 0, N - 1, 1'b0);
    idle(1);
    drain();

    // Three back-to-back frames.
    send_range(0, 0, N - 1, 1'b0);
    send_range(2000, 0, N - 1, 1'b0);
    send_range(4000, 0, N - 1, 1'b0);
    idle(1);
    drain();
    check("b2b_run", 64'(last_run), 64'(3 * N));

    // Bubbled input.
    send_range(500, 0, N - 1, 1'b1);
    idle(1);
    drain();

`ifdef REORDER_FRAME_ERR_EN
    check("ferr_clear", 64'(io.frame_err), 64'd0);
`endif

    // Resync after 300 samples.
    fr0 = frames_out;
    send_range(7000, 0, 299, 1'b0);
    send_range(100, 0, N - 1, 1'b0);
    idle(1);
    drain();
    idle(1100);
    check("resync_frames", 64'(frames_out - fr0), 64'd1);
`ifdef REORDER_FRAME_ERR_EN
    check("ferr_set", 64'(io.frame_err), 64'd1);
`endif

    // Reset while bin 500 is on the output.
    send_range(3000, 0, N - 1, 1'b0);
    idle(1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (io.out_valid && io.out_bin == 10'd500) break;
    end
    check("bin500_seen", 64'(io.out_bin), 64'd500);
    #2 rst = 1'b1;
    #1;
    check("midrst_outs",
          64'({io.out_valid, io.out_first, io.out_last,
               io.out_bin, io.out_re, io.out_im}), 64'd0);
`ifdef REORDER_FRAME_ERR_EN
    check("ferr_rst", 64'(io.frame_err), 64'd0);
`endif
    exp_q.delete();
    t_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1100);
    check("no_leftover", 64'(io.out_valid), 64'd0);
    send_range(600, 0, N - 1, 1'b0);
    idle(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
